// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
// Shared constants for the digital clock timebase: reference crystal rate,
// default divider and strobe field widths, and a helper that tests whether the
// low bits of a counter value are all ones.
// -----------------------------------------------------------------------------
package clock_pkg;

  localparam int unsigned REFCLK_HZ       = 32'd32768;
  localparam int unsigned SYNC_STAGES_MIN = 32'd2;
  localparam int unsigned DIV_WIDTH       = 32'd15;
  localparam int unsigned SLOW_SET_BITS   = 32'd14;
  localparam int unsigned FAST_SET_BITS   = 32'd12;
  localparam int unsigned DEBOUNCE_BITS   = 32'd8;

  // True when value[bits-1:0] is all ones, i.e. the next increment wraps that
  // field. bits must be in 1..31.
  function automatic logic low_bits_set(input logic [31:0] value,
                                        input int unsigned bits);
    logic [31:0] mask;
    mask = (32'd1 << bits) - 32'd1;
    return ((value & mask) == mask);
  endfunction

endpackage

// File: rtl/refclk_edge_sync.sv
// -----------------------------------------------------------------------------
// refclk_edge_sync
// Brings the asynchronous reference clock into the i_clk domain through a
// SYNC_STAGES-deep flop chain, keeps one history flop behind the chain and
// detects rising edges.
//
// Ports:
//   i_clk        system clock
//   i_reset_n    asynchronous active-low reset
//   i_refclk     asynchronous reference clock (at most i_clk/4)
//   o_edge       combinational rising-edge term (sync_last & ~history); the
//                divider consumes this so its strobes line up with o_edge_stb
//   o_edge_stb   registered copy of o_edge, one i_clk cycle per refclk rise
// -----------------------------------------------------------------------------
module refclk_edge_sync
  import clock_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_MIN
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_refclk,
  output logic o_edge,
  output logic o_edge_stb
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   hist_r;
  logic                   edge_stb_r;
  logic                   edge_s;

  // Metastability chain, history flop and registered edge pulse.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync_r     <= '0;
      hist_r     <= 1'b0;
      edge_stb_r <= 1'b0;
    end else begin
      sync_r     <= {sync_r[SYNC_STAGES-2:0], i_refclk};
      hist_r     <= sync_r[SYNC_STAGES-1];
      edge_stb_r <= edge_s;
    end
  end

  // Rising edge: synchronised level is high now but was low one cycle ago.
  always_comb begin
    edge_s = 1'b0;
    if (sync_r[SYNC_STAGES-1] && !hist_r) begin
      edge_s = 1'b1;
    end else begin
      edge_s = 1'b0;
    end
  end

  assign o_edge     = edge_s;
  assign o_edge_stb = edge_stb_r;

endmodule

// File: rtl/clock_strobe_gen.sv
// -----------------------------------------------------------------------------
// clock_strobe_gen
// Timebase for the digital clock. Counts synchronised refclk rising edges in a
// free-running DIV_WIDTH-bit counter and emits single-cycle strobes when a low
// field of the counter wraps: 1 Hz (whole counter), slow time-set, fast
// time-set and button debounce. All strobes share the cycle of o_refclk_stb,
// so slower strobes always coincide with the faster ones.
//
// Ports:
//   i_clk           system clock, all logic on its rising edge
//   i_reset_n       asynchronous active-low reset
//   i_refclk        asynchronous reference clock (at most i_clk/4)
//   o_refclk_stb    one-cycle pulse per synchronised refclk rising edge
//   o_1hz_stb       strobe every 2^DIV_WIDTH refclk edges
//   o_slow_set_stb  strobe every 2^SLOW_SET_BITS refclk edges
//   o_fast_set_stb  strobe every 2^FAST_SET_BITS refclk edges
//   o_debounce_stb  strobe every 2^DEBOUNCE_BITS refclk edges
// Field widths must satisfy DEBOUNCE_BITS <= FAST_SET_BITS <= SLOW_SET_BITS
// <= DIV_WIDTH < 32.
// -----------------------------------------------------------------------------
module clock_strobe_gen #(
  parameter int unsigned SYNC_STAGES   = clock_pkg::SYNC_STAGES_MIN,
  parameter int unsigned DIV_WIDTH     = clock_pkg::DIV_WIDTH,
  parameter int unsigned SLOW_SET_BITS = clock_pkg::SLOW_SET_BITS,
  parameter int unsigned FAST_SET_BITS = clock_pkg::FAST_SET_BITS,
  parameter int unsigned DEBOUNCE_BITS = clock_pkg::DEBOUNCE_BITS
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_refclk,
  output logic o_refclk_stb,
  output logic o_1hz_stb,
  output logic o_slow_set_stb,
  output logic o_fast_set_stb,
  output logic o_debounce_stb
);

  logic                 edge_s;
  logic                 edge_stb_s;
  logic [DIV_WIDTH-1:0] cnt_r;
  logic                 hz1_r;
  logic                 slow_r;
  logic                 fast_r;
  logic                 deb_r;
  logic                 wrap_all_s;
  logic                 wrap_slow_s;
  logic                 wrap_fast_s;
  logic                 wrap_deb_s;

  refclk_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_refclk   (i_refclk),
    .o_edge     (edge_s),
    .o_edge_stb (edge_stb_s)
  );

  // Field-wrap decode: a strobe is due when this edge rolls its field over.
  always_comb begin
    wrap_all_s  = 1'b0;
    wrap_slow_s = 1'b0;
    wrap_fast_s = 1'b0;
    wrap_deb_s  = 1'b0;
    if (edge_s) begin
      wrap_all_s  = clock_pkg::low_bits_set(32'(cnt_r), DIV_WIDTH);
      wrap_slow_s = clock_pkg::low_bits_set(32'(cnt_r), SLOW_SET_BITS);
      wrap_fast_s = clock_pkg::low_bits_set(32'(cnt_r), FAST_SET_BITS);
      wrap_deb_s  = clock_pkg::low_bits_set(32'(cnt_r), DEBOUNCE_BITS);
    end else begin
      wrap_all_s  = 1'b0;
      wrap_slow_s = 1'b0;
      wrap_fast_s = 1'b0;
      wrap_deb_s  = 1'b0;
    end
  end

  // Edge counter (wraps naturally) and registered strobes.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_r  <= '0;
      hz1_r  <= 1'b0;
      slow_r <= 1'b0;
      fast_r <= 1'b0;
      deb_r  <= 1'b0;
    end else begin
      if (edge_s) begin
        cnt_r <= cnt_r + DIV_WIDTH'(1'b1);
      end else begin
        cnt_r <= cnt_r;
      end
      hz1_r  <= wrap_all_s;
      slow_r <= wrap_slow_s;
      fast_r <= wrap_fast_s;
      deb_r  <= wrap_deb_s;
    end
  end

  assign o_refclk_stb   = edge_stb_s;
  assign o_1hz_stb      = hz1_r;
  assign o_slow_set_stb = slow_r;
  assign o_fast_set_stb = fast_r;
  assign o_debounce_stb = deb_r;

endmodule

// File: tb/tb_clock_strobe_gen.sv
// -----------------------------------------------------------------------------
// tb_clock_strobe_gen
// Drives one refclk into two instances: default widths (dut_d) and shrunk
// widths 6/4/3/2 (dut_s). A per-instance monitor counts edge pulses since
// reset and, on each pulse, predicts which strobes are due from that count.
// -----------------------------------------------------------------------------
module tb_clock_strobe_gen;

  logic clk;
  logic rst_n;
  logic refclk;

  logic d_ref, d_1hz, d_slow, d_fast, d_deb;
  logic s_ref, s_1hz, s_slow, s_fast, s_deb;

  int total;
  int bad;

  int d_n, d_c1, d_cs, d_cf, d_cd;
  int s_n, s_c1, s_cs, s_cf, s_cd;
  logic d_prev, s_prev;

  clock_strobe_gen dut_d (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_refclk       (refclk),
    .o_refclk_stb   (d_ref),
    .o_1hz_stb      (d_1hz),
    .o_slow_set_stb (d_slow),
    .o_fast_set_stb (d_fast),
    .o_debounce_stb (d_deb)
  );

  clock_strobe_gen #(
    .DIV_WIDTH     (6),
    .SLOW_SET_BITS (4),
    .FAST_SET_BITS (3),
    .DEBOUNCE_BITS (2)
  ) dut_s (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_refclk       (refclk),
    .o_refclk_stb   (s_ref),
    .o_1hz_stb      (s_1hz),
    .o_slow_set_stb (s_slow),
    .o_fast_set_stb (s_fast),
    .o_debounce_stb (s_deb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    if (obs !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor for the default-width instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("d_rst", {27'd0, d_ref, d_1hz, d_slow, d_fast, d_deb}, 32'd0);
      d_n <= 0; d_c1 <= 0; d_cs <= 0; d_cf <= 0; d_cd <= 0; d_prev <= 1'b0;
    end else begin
      if (d_ref) begin
        chk("d_b2b",  {31'd0, d_prev}, 32'd0);
        chk("d_deb",  {31'd0, d_deb},  {31'd0, ((d_n + 1) % 256)   == 0});
        chk("d_fast", {31'd0, d_fast}, {31'd0, ((d_n + 1) % 4096)  == 0});
        chk("d_slow", {31'd0, d_slow}, {31'd0, ((d_n + 1) % 16384) == 0});
        chk("d_1hz",  {31'd0, d_1hz},  {31'd0, ((d_n + 1) % 32768) == 0});
        d_n <= d_n + 1;
      end else if (d_1hz | d_slow | d_fast | d_deb) begin
        chk("d_orphan", {28'd0, d_1hz, d_slow, d_fast, d_deb}, 32'd0);
      end
      d_c1 <= d_c1 + int'(d_1hz);
      d_cs <= d_cs + int'(d_slow);
      d_cf <= d_cf + int'(d_fast);
      d_cd <= d_cd + int'(d_deb);
      d_prev <= d_ref;
    end
  end

  // Monitor for the shrunk-width instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("s_rst", {27'd0, s_ref, s_1hz, s_slow, s_fast, s_deb}, 32'd0);
      s_n <= 0; s_c1 <= 0; s_cs <= 0; s_cf <= 0; s_cd <= 0; s_prev <= 1'b0;
    end else begin
      if (s_ref) begin
        chk("s_b2b",  {31'd0, s_prev}, 32'd0);
        chk("s_deb",  {31'd0, s_deb},  {31'd0, ((s_n + 1) % 4)  == 0});
        chk("s_fast", {31'd0, s_fast}, {31'd0, ((s_n + 1) % 8)  == 0});
        chk("s_slow", {31'd0, s_slow}, {31'd0, ((s_n + 1) % 16) == 0});
        chk("s_1hz",  {31'd0, s_1hz},  {31'd0, ((s_n + 1) % 64) == 0});
        s_n <= s_n + 1;
      end else if (s_1hz | s_slow | s_fast | s_deb) begin
        chk("s_orphan", {28'd0, s_1hz, s_slow, s_fast, s_deb}, 32'd0);
      end
      s_c1 <= s_c1 + int'(s_1hz);
      s_cs <= s_cs + int'(s_slow);
      s_cf <= s_cf + int'(s_fast);
      s_cd <= s_cd + int'(s_deb);
      s_prev <= s_ref;
    end
  end

  // One refclk period of 20 cycles; checks the rise-to-pulse latency.
  task automatic slow_edge();
    int lat;
    logic found;
    refclk = 1'b1;
    lat = 0;
    found = 1'b0;
    while (!found && lat < 8) begin
      cyc(1);
      lat = lat + 1;
      if (s_ref) found = 1'b1;
    end
    chk("lat", {31'd0, found && lat >= 3 && lat <= 4}, 32'd1);
    cyc(10 - lat);
    refclk = 1'b0;
    cyc(10);
  endtask

  // One refclk period at the fastest legal rate (i_clk/4).
  task automatic fast_edge();
    refclk = 1'b1;
    cyc(2);
    refclk = 1'b0;
    cyc(2);
  endtask

  initial begin
    int lat;
    total  = 0;
    bad    = 0;
    rst_n  = 1'b0;
    refclk = 1'b0;

    // Reset held with refclk toggling; monitors check outputs stay low.
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      refclk = ~refclk;
    end
    refclk = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(4);

    // 199 slow edges: shrunk instance wraps through 64 and 128.
    for (int e = 0; e < 199; e++) slow_edge();
    chk("s_n199",  s_n,  32'd199);
    chk("d_n199",  d_n,  32'd199);
    chk("s_c1",    s_c1, 32'd3);
    chk("s_cs",    s_cs, 32'd12);
    chk("s_cf",    s_cf, 32'd24);
    chk("s_cd",    s_cd, 32'd49);
    chk("d_cd0",   d_cd, 32'd0);

    // Edge 200 carries a debounce strobe; reset lands while it is high.
    refclk = 1'b1;
    lat = 0;
    while (!s_ref && lat < 8) begin
      cyc(1);
      lat = lat + 1;
    end
    chk("e200_ref", {31'd0, s_ref}, 32'd1);
    chk("e200_deb", {31'd0, s_deb}, 32'd1);
    chk("e200_fst", {31'd0, s_fast}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_drop", {22'd0, d_ref, d_1hz, d_slow, d_fast, d_deb,
                     s_ref, s_1hz, s_slow, s_fast, s_deb}, 32'd0);
    cyc(3);
    refclk = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(4);

    // 5000 edges at i_clk/4 from a fresh count.
    for (int e = 0; e < 5000; e++) fast_edge();
    cyc(8);
    chk("d_n5000", d_n,  32'd5000);
    chk("s_n5000", s_n,  32'd5000);
    chk("d_cd_f",  d_cd, 32'd19);
    chk("d_cf_f",  d_cf, 32'd1);
    chk("d_cs_f",  d_cs, 32'd0);
    chk("d_c1_f",  d_c1, 32'd0);
    chk("s_c1_f",  s_c1, 32'd78);
    chk("s_cs_f",  s_cs, 32'd312);
    chk("s_cf_f",  s_cf, 32'd625);
    chk("s_cd_f",  s_cd, 32'd1250);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
